// File: rtl/mem_loader.sv
// mem_loader: turns a byte stream into DataWidth-bit words and writes them to
// consecutive addresses of a single-port BRAM (active-low Mem_En/Write_EN).
// Words are assembled big-endian: the first byte of a word is its top lane.
//
// Build option: MEM_LOADER_CHECKSUM_EN adds a CHECK state that takes one
// trailer byte after the last word and compares it against the 8-bit sum of
// all data bytes. Without it, Checksum_Err is tied low.
//
// Handshake: a byte moves on a posedge where Byte_Valid and Byte_Ready are both
// 1. Byte_Ready is registered from the next state, so it is high exactly while
// the FSM sits in COLLECT (or CHECK). The source must hold Byte_In/Byte_Valid
// until the transfer; bytes offered while Byte_Ready is low stay with the source.
module mem_loader #(
    parameter int AddrWidth = 8,
    parameter int DataWidth = 16,
    parameter int WordCount = 256
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [AddrWidth-1:0] Base_Addr,
    input  logic [7:0]           Byte_In,
    input  logic                 Byte_Valid,
    output logic                 Byte_Ready,
    output logic [DataWidth-1:0] DOut,
    output logic [AddrWidth-1:0] Address,
    output logic                 Write_EN,
    output logic                 Mem_En,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Checksum_Err,
    output logic [2:0]           State_Dbg
);

    localparam int BytesPerWord = DataWidth / 8;
    localparam int BCW          = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
    localparam logic [BCW-1:0]       BC_LAST = BCW'(BytesPerWord - 1);
    localparam logic [AddrWidth-1:0] WC_LAST = AddrWidth'(WordCount - 1);

`ifdef MEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3,
        S_CHECK   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_DONE    = 3'd3
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [DataWidth-1:0]   dout_q, dout_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [AddrWidth-1:0]   word_cnt_q, word_cnt_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   wen_n_q, wen_n_d;
    logic                   men_n_q, men_n_d;
    logic                   accept;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]             sum_q, sum_d;
    logic                   chk_err_q, chk_err_d;
`endif

    // A byte is consumed only when the registered ready and the source valid meet.
    assign accept = ready_q & Byte_Valid;

    // Next-state logic, then all registered outputs derived from the next state.
    always_comb begin
        state_d    = state_q;
        dout_d     = dout_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
`ifdef MEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        chk_err_d  = chk_err_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                // A start from DONE is a full restart of the load.
                if (Start) begin
                    addr_d     = Base_Addr;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    state_d    = S_COLLECT;
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d      = '0;
                    chk_err_d  = 1'b0;
`endif
                end
            end

            S_COLLECT: begin
                if (accept) begin
                    // Lane k is filled by byte number (BytesPerWord-1-k) of the word.
                    for (int k = 0; k < BytesPerWord; k++) begin
                        if (byte_cnt_q == BCW'(BytesPerWord - 1 - k)) begin
                            dout_d[k*8 +: 8] = Byte_In;
                        end
                    end
`ifdef MEM_LOADER_CHECKSUM_EN
                    sum_d = sum_q + Byte_In;
`endif
                    if (byte_cnt_q == BC_LAST) begin
                        byte_cnt_d = '0;
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end
            end

            S_WRITE: begin
                // Address only advances after the strobe cycle, so it stays
                // stable across the memory's negedge capture.
                if (word_cnt_q == WC_LAST) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    addr_d     = addr_q + AddrWidth'(1);
                    word_cnt_d = word_cnt_q + AddrWidth'(1);
                    state_d    = S_COLLECT;
                end
            end

`ifdef MEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                // The trailer is compared and dropped; it never reaches memory.
                if (accept) begin
                    chk_err_d = (Byte_In != sum_q);
                    state_d   = S_DONE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MEM_LOADER_CHECKSUM_EN
        ready_d = (state_d == S_COLLECT) || (state_d == S_CHECK);
        busy_d  = (state_d == S_COLLECT) || (state_d == S_WRITE) || (state_d == S_CHECK);
`else
        ready_d = (state_d == S_COLLECT);
        busy_d  = (state_d == S_COLLECT) || (state_d == S_WRITE);
`endif
        done_d  = (state_d == S_DONE);
        // Strobes are low only for the single WRITE cycle; no reads are issued.
        men_n_d = (state_d != S_WRITE);
        wen_n_d = (state_d != S_WRITE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            dout_q     <= '0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wen_n_q    <= 1'b1;
            men_n_q    <= 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dout_q     <= dout_d;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wen_n_q    <= wen_n_d;
            men_n_q    <= men_n_d;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            chk_err_q  <= chk_err_d;
`endif
        end
    end

    assign Byte_Ready = ready_q;
    assign DOut       = dout_q;
    assign Address    = addr_q;
    assign Write_EN   = wen_n_q;
    assign Mem_En     = men_n_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign State_Dbg  = state_q;
`ifdef MEM_LOADER_CHECKSUM_EN
    assign Checksum_Err = chk_err_q;
`else
    assign Checksum_Err = 1'b0;
`endif

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Upstream feeder for the 256x16 single-port BRAM. Assembles a byte stream from a serial receiver into words and writes them to consecutive memory addresses.
- Used to load program images into memory before the CPU is released.
- Drives the memory's DIn, Address, Write_EN and Mem_En directly.
- Runs on the posedge of Clk, so its outputs are stable at the memory's negedge sample point.

Parameters:
- AddrWidth, 8, memory address width.
- DataWidth, 16, memory word width. Must be a multiple of 8. BytesPerWord = DataWidth/8.
- WordCount, 256, number of words written per load. Range 1..2^AddrWidth.

Ports:
- Clk  input  1  system clock; block logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  begin a load; sampled at posedge.
- Base_Addr  input  AddrWidth  first write address; latched at Start.
- Byte_In  input  8  incoming byte.
- Byte_Valid  input  1  Byte_In holds a valid byte.
- Byte_Ready  output  1  block accepts Byte_In this cycle.
- DOut  output  DataWidth  assembled word; connects to memory DIn.
- Address  output  AddrWidth  memory address.
- Write_EN  output  1  memory write enable, active low.
- Mem_En  output  1  memory enable, active low.
- Busy  output  1  load in progress.
- Done  output  1  load completed.
- Checksum_Err  output  1  checksum mismatch (see Optional Feature).

Behaviour:
- Interface:
  - One clock, Clk. Reset is synchronous and active-high; all registers clear on a posedge of Clk with Reset=1.
  - Reset values: DOut=0, Address=0, Write_EN=1, Mem_En=1, Byte_Ready=0, Busy=0, Done=0, Checksum_Err=0, state=IDLE, byte and word counters=0.
- Handshake:
  - A byte transfers on a posedge where Byte_Valid and Byte_Ready are both 1.
  - Byte_Ready is a registered function of state: 1 only in COLLECT.
  - The upstream holds Byte_In/Byte_Valid until the transfer. Bytes presented outside COLLECT are not consumed and are not lost.
- Word assembly:
  - Big-endian: the first byte of each word lands in DOut[DataWidth-1 -: 8].
  - Later bytes fill successively lower byte lanes.
- States:
  - IDLE: Busy=0, Byte_Ready=0.
    - Start=1 -> latch Address=Base_Addr, clear counters, Done=0, Checksum_Err=0, go to COLLECT.
  - COLLECT: Busy=1, Byte_Ready=1.
    - Each accepted byte increments the byte counter.
    - The byte that completes the word -> WRITE at the next posedge. Byte_Ready drops in the same transition.
  - WRITE: exactly 1 cycle, Byte_Ready=0.
    - Mem_En=0 and Write_EN=0. DOut and Address are held stable for the whole cycle; the memory captures on the intervening negedge.
    - Next posedge: Mem_En=1, Write_EN=1.
    - If this was word WordCount-1 -> DONE (or CHECK when the feature is on).
    - Otherwise Address <= Address+1 and the state returns to COLLECT.
  - DONE: Busy=0, Done=1, held until Start or Reset.
    - Start in DONE behaves as Start in IDLE (restart).
- Latency: per word, BytesPerWord accept cycles plus 1 write cycle. At the default width, the minimum is 3 Clk per word when Byte_Valid is held at 1.
- Boundary conditions:
  - Address wraps modulo 2^AddrWidth. Base_Addr=8'hFF with WordCount≥2 writes 8'hFF, then 8'h00, and so on.
  - Start while Busy=1 is ignored; the latched Base_Addr is unchanged.
  - Reset mid-load: the next posedge forces IDLE with all reset values.
    - Words already written remain in memory. A partially assembled word is discarded.
    - Mem_En/Write_EN are inactive from that posedge on.
  - Reset and Start asserted together: Reset wins.
  - WordCount=1: one COLLECT/WRITE pass, then DONE.
- Mem_En and Write_EN are never low outside WRITE; the block never issues reads.

Optional Feature:
- Macro: MEM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running sum, modulo 256, of every data byte accepted.
  - After the final WRITE the block enters CHECK: Byte_Ready=1, Busy=1.
  - One trailer byte is accepted in CHECK. At the next posedge: Checksum_Err <= (trailer != sum), state -> DONE.
  - Checksum_Err holds until the next Start or Reset.
  - The trailer byte is never written to memory.
- Undefined: no CHECK state, no sum register, Checksum_Err tied to 0.

Test Plan:
- Reset, then Start with Base_Addr=8'h10, WordCount=4; stream bytes 12 34 56 78 9A BC DE F0, Byte_Valid held high.
  - Memory 0x10..0x13 = 1234, 5678, 9ABC, DEF0.
  - Done=1 twelve cycles after the first transfer.
  - Mem_En/Write_EN low for exactly 4 single cycles.
- Same load with Byte_Valid toggled 1/0 every cycle.
  - Identical memory contents.
  - Byte_Ready=0 in every WRITE cycle; no byte dropped or duplicated.
- Base_Addr=8'hFE, WordCount=3, words AAAA BBBB CCCC.
  - mem[FE]=AAAA, mem[FF]=BBBB, mem[00]=CCCC (wrap).
- Assert Reset after 3 bytes of a WordCount=4 load at Base 0x20.
  - mem[20] written; mem[21] unchanged.
  - All outputs at reset values the next cycle; a subsequent Start reloads cleanly.
- Pulse Start while Busy, with Base_Addr changed to 0x80.
  - Ignored; writes continue at the original addresses.
  - Start in DONE restarts the load and clears Done.
- With MEM_LOADER_CHECKSUM_EN, WordCount=1, bytes 01 02:
  - Trailer 03 -> Checksum_Err=0.
  - Repeat with trailer 04 -> Checksum_Err=1, Done=1, and mem still holds 0102.
